cordic_neuron_seq: RTL and testbench
====================================

Name: cordic_neuron_seq

Overview:
- Sequential multi-tap neuron for the CORDIC inference datapath.
- Streams up to MAX_TAPS (input, weight) pairs through one iterative linear-mode CORDIC unit, accumulating sum(x_i*w_i) + bias.
- Saturates the sum to the data width, then applies a selectable activation.
- Parametrised successor to the single-shot reconfigurable CORDIC top level. Adds variable tap count, valid/ready handshakes on both sides, configurable iteration count and saturation reporting.

Parameters:
- WIDTH, 15, MSB index of data buses (buses are [WIDTH:0], signed fixed point)
- FRAC, 10, fractional bits (1.0 = 2^FRAC)
- ITER, 12, CORDIC iterations per tap (shift index i = 0..ITER-1)
- MAX_TAPS, 8, maximum taps per neuron evaluation
- GUARD, 4, extra accumulator MSBs

Ports:
- clk  in  1  clock, rising edge
- ext_reset_n  in  1  asynchronous active-low reset
- start  in  1  begin evaluation; sampled only in IDLE
- n_taps  in  clog2(MAX_TAPS+1)  tap count, latched at start; values >MAX_TAPS clamp to MAX_TAPS
- bias  in  WIDTH+1  accumulator seed, latched at start
- sel  in  2  activation select, latched at start
- af_en  in  1  activation enable, latched at start
- in_valid  in  1  x_in/w_in valid
- in_ready  out  1  block accepts a pair
- x_in  in  WIDTH+1  input operand
- w_in  in  WIDTH+1  weight; |w| < 2.0 required
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- mac_out  out  WIDTH+1  saturated sum, pre-activation
- z  out  WIDTH+1  activated result
- sat  out  1  mac_out was clipped
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - All outputs 0: in_ready, out_valid, mac_out, z, sat, busy.
  - Internal registers cleared. In-flight work is discarded.
- IDLE:
  - start=1 latches n_taps, bias (sign-extended to accumulator width WIDTH+1+GUARD), sel, af_en.
  - n_taps>0 goes to LOAD; n_taps=0 goes to ACT.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - On in_valid: capture x, set zreg=w (width WIDTH+2), i=0, go to ITERATE.
  - Gaps in in_valid stall without limit.
- ITERATE, one iteration per cycle:
  - d = +1 if zreg >= 0, else -1.
  - acc += d*(x >>> i) (arithmetic shift, truncating).
  - zreg -= d*(2^FRAC >> i).
  - After iteration ITER-1: taps remaining goes to LOAD, else ACT.
- ACT, 1 cycle:
  - Saturate acc to [-2^WIDTH, 2^WIDTH-1]; sat=1 if clipped.
  - Register mac_out.
  - af_en=0: z = mac_out.
  - af_en=1 and sel 00: identity.
  - sel 01: ReLU (negative becomes 0).
  - sel 10: hard-tanh, clamp to [-2^FRAC, 2^FRAC].
  - sel 11: hard-sigmoid, clamp((mac>>>2) + 2^(FRAC-1), 0, 2^FRAC).
  - Go to DONE.
- DONE:
  - out_valid=1. mac_out, z, sat held stable until out_ready.
  - out_valid && out_ready goes to IDLE, with out_valid low the next cycle.
  - A start in that same cycle is ignored.
- Latency, with in_valid continuously high:
  - start sampled at edge k; out_valid high after edge k + N*(ITER+1) + 1.
  - Defaults: N=2 gives k+27; N=0 gives k+1.
  - Each idle in_valid cycle adds 1.
- Accuracy: per-tap error <= |x|*2^-(ITER-1) + ITER LSB. Bench tolerance is ±4 LSB per tap at defaults.
- Accumulator overflow: GUARD bits prevent wrap for MAX_TAPS terms of |x*w| < 2^(WIDTH-FRAC+1). Beyond that the result is undefined.

Test Plan:
- Reset: hold ext_reset_n=0 with random inputs -> all outputs 0, in_ready=0. Assert reset mid-ITERATE -> outputs 0 and IDLE immediately; the next run produces the correct result.
- Two taps: bias=0x0080, pairs (0x0200,0x0200) and (0xFD80,0x0100), af_en=0, in_valid high -> out_valid after edge k+27, mac_out=z=0x00E0 ±8 LSB, sat=0.
- Saturation: n_taps=8, each x=0x7C00, w=0x0600, bias=0, af_en=1, sel=10 -> mac_out=0x7FFF, sat=1, z=0x0400. Repeat with w=0xFA00 -> mac_out=0x8000, z=0xFC00.
- ReLU: n_taps=1, x=0x0400, w=0xFE00, bias=0, af_en=1, sel=01 -> mac_out=0xFE00 ±4, z=0x0000.
- Zero taps and sigmoid: n_taps=0, bias=0, af_en=1, sel=11 -> out_valid after edge k+1, z=0x0200. Same with n_taps=9 -> behaves as 8 taps.
- Backpressure: drop in_valid for 3 cycles mid-stream -> latency +3, result unchanged. Hold out_ready=0 for 5 cycles -> outputs stable and out_valid high throughout. A start during DONE is ignored.

Source files
------------

// File: rtl/cordic_neuron_seq.sv
// rtl/cordic_neuron_seq.sv - sequential multi-tap linear-CORDIC neuron with saturation and activation
module cordic_neuron_seq #(
  parameter int WIDTH    = 15,
  parameter int FRAC     = 10,
  parameter int ITER     = 12,
  parameter int MAX_TAPS = 8,
  parameter int GUARD    = 4
) (
  input  logic                          clk,
  input  logic                          ext_reset_n,
  input  logic                          start,
  input  logic [$clog2(MAX_TAPS+1)-1:0] n_taps,
  input  logic [WIDTH:0]                bias,
  input  logic [1:0]                    sel,
  input  logic                          af_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH:0]                x_in,
  input  logic [WIDTH:0]                w_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH:0]                mac_out,
  output logic [WIDTH:0]                z,
  output logic                          sat,
  output logic                          busy
);

  localparam int NW = $clog2(MAX_TAPS + 1);
  localparam int DW = WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 1 + GUARD;
  localparam int ZW = WIDTH + 2;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [NW-1:0] MAX_N  = NW'(MAX_TAPS);
  localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);
  localparam logic [ZW-1:0] Z_ONE  = ZW'(1) << FRAC;

  localparam logic signed [AW-1:0] ACC_MAX = AW'((1 << WIDTH) - 1);
  localparam logic signed [AW-1:0] ACC_MIN = AW'(-(1 << WIDTH));

  localparam logic signed [DW-1:0] D_MAX     = {1'b0, {WIDTH{1'b1}}};
  localparam logic signed [DW-1:0] D_MIN     = {1'b1, {WIDTH{1'b0}}};
  localparam logic signed [DW-1:0] ONE_D     = DW'(1) << FRAC;
  localparam logic signed [DW-1:0] NEG_ONE_D = -ONE_D;
  localparam logic signed [EW-1:0] HALF_E    = EW'(1) << (FRAC - 1);
  localparam logic signed [EW-1:0] ONE_E     = EW'(1) << FRAC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_ACT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NW-1:0]          taps_left_q, taps_left_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic signed [DW-1:0]   x_q, x_d;
  logic signed [ZW-1:0]   zreg_q, zreg_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [1:0]             sel_q, sel_d;
  logic                   af_en_q, af_en_d;
  logic [DW-1:0]          mac_q, mac_d;
  logic [DW-1:0]          z_q, z_d;
  logic                   sat_q, sat_d;

  logic [NW-1:0]          n_eff;
  logic signed [AW-1:0]   x_ext;
  logic signed [AW-1:0]   x_shift;
  logic [ZW-1:0]          z_step;
  logic signed [DW-1:0]   mac_sat;
  logic signed [DW-1:0]   act_val;
  logic                   clip;
  logic signed [EW-1:0]   sig_ext;
  logic signed [EW-1:0]   sig_sum;

  // State register; reset discards any evaluation in flight
  always_ff @(posedge clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only matters in IDLE, taps loop LOAD/ITER until none remain
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n_taps == '0) ? S_ACT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (iter_q == LAST_I) begin
          state_d = (taps_left_q != '0) ? S_LOAD : S_ACT;
        end
      end
      S_ACT:   state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the registered state
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Saturate the accumulator to the data width and apply the latched activation
  always_comb begin
    clip    = 1'b0;
    mac_sat = acc_q[DW-1:0];
    if (acc_q > ACC_MAX) begin
      mac_sat = D_MAX;
      clip    = 1'b1;
    end else if (acc_q < ACC_MIN) begin
      mac_sat = D_MIN;
      clip    = 1'b1;
    end

    sig_ext = {mac_sat[DW-1], mac_sat};
    sig_sum = (sig_ext >>> 2) + HALF_E;

    act_val = mac_sat;
    if (af_en_q) begin
      case (sel_q)
        2'b01: begin
          if (mac_sat[DW-1]) begin
            act_val = '0;
          end
        end
        2'b10: begin
          if (mac_sat > ONE_D) begin
            act_val = ONE_D;
          end else if (mac_sat < NEG_ONE_D) begin
            act_val = NEG_ONE_D;
          end
        end
        2'b11: begin
          if (sig_sum[EW-1]) begin
            act_val = '0;
          end else if (sig_sum > ONE_E) begin
            act_val = ONE_D;
          end else begin
            act_val = sig_sum[DW-1:0];
          end
        end
        default: act_val = mac_sat;
      endcase
    end
  end

  // Datapath next values: latch config, capture pairs, one CORDIC step per ITER cycle
  always_comb begin
    n_eff   = (n_taps > MAX_N) ? MAX_N : n_taps;
    x_ext   = {{(AW - DW){x_q[DW-1]}}, x_q};
    x_shift = x_ext >>> iter_q;
    z_step  = Z_ONE >> iter_q;

    taps_left_d = taps_left_q;
    iter_d      = iter_q;
    x_d         = x_q;
    zreg_d      = zreg_q;
    acc_d       = acc_q;
    sel_d       = sel_q;
    af_en_d     = af_en_q;
    mac_d       = mac_q;
    z_d         = z_q;
    sat_d       = sat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          taps_left_d = n_eff;
          acc_d       = {{GUARD{bias[DW-1]}}, bias};
          sel_d       = sel;
          af_en_d     = af_en;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          x_d         = x_in;
          zreg_d      = {w_in[DW-1], w_in};
          iter_d      = '0;
          taps_left_d = taps_left_q - NW'(1);
        end
      end
      S_ITER: begin
        // Drive the residual weight toward zero; the matching shifted x builds the product
        if (!zreg_q[ZW-1]) begin
          acc_d  = acc_q + x_shift;
          zreg_d = zreg_q - z_step;
        end else begin
          acc_d  = acc_q - x_shift;
          zreg_d = zreg_q + z_step;
        end
        iter_d = iter_q + IW'(1);
      end
      S_ACT: begin
        mac_d = mac_sat;
        z_d   = act_val;
        sat_d = clip;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; results change only in ACT so they hold through DONE
  always_ff @(posedge clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      taps_left_q <= '0;
      iter_q      <= '0;
      x_q         <= '0;
      zreg_q      <= '0;
      acc_q       <= '0;
      sel_q       <= '0;
      af_en_q     <= 1'b0;
      mac_q       <= '0;
      z_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      taps_left_q <= taps_left_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      zreg_q      <= zreg_d;
      acc_q       <= acc_d;
      sel_q       <= sel_d;
      af_en_q     <= af_en_d;
      mac_q       <= mac_d;
      z_q         <= z_d;
      sat_q       <= sat_d;
    end
  end

  assign mac_out = mac_q;
  assign z       = z_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_cordic_neuron_seq.sv
// tb/tb_cordic_neuron_seq.sv - randomized self-checking bench for cordic_neuron_seq
`timescale 1ns/1ps
module tb_cordic_neuron_seq;

  localparam int MAX_TAPS = 8;
  localparam int NW       = $clog2(MAX_TAPS + 1);
  localparam int TAP_LAT  = 13;

  logic          clk = 1'b0;
  logic          ext_reset_n = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] n_taps = '0;
  logic [15:0]   bias = '0;
  logic [1:0]    sel = '0;
  logic          af_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   x_in = '0;
  logic [15:0]   w_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   mac_out;
  logic [15:0]   z;
  logic          sat;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] xs [0:8];
  logic [15:0] ws [0:8];

  cordic_neuron_seq dut (
    .clk         (clk),
    .ext_reset_n (ext_reset_n),
    .start       (start),
    .n_taps      (n_taps),
    .bias        (bias),
    .sel         (sel),
    .af_en       (af_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_in        (x_in),
    .w_in        (w_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .mac_out     (mac_out),
    .z           (z),
    .sat         (sat),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: exact real-valued dot product plus bias, then ideal clamps
  function automatic real ref_sum(input int n, input logic [15:0] b);
    real s;
    s = real'(int'($signed(b)));
    for (int j = 0; j < n; j++) begin
      s = s + real'(int'($signed(xs[j]))) * real'(int'($signed(ws[j]))) / 1024.0;
    end
    return s;
  endfunction

  function automatic real clamp_r(input real v, input real lo, input real hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic real act_r(input real v, input logic [1:0] s, input logic a);
    if (!a) return v;
    case (s)
      2'b01:   return (v < 0.0) ? 0.0 : v;
      2'b10:   return clamp_r(v, -1024.0, 1024.0);
      2'b11:   return clamp_r(v / 4.0 + 512.0, 0.0, 1024.0);
      default: return v;
    endcase
  endfunction

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real sv(input logic [15:0] v);
    return real'(int'($signed(v)));
  endfunction

  // Start an evaluation, feed min(n,8) pairs from xs/ws, wait for out_valid; lat=-1 on timeout
  task automatic run_eval(input int n_req, input logic [15:0] b, input logic [1:0] s,
                          input logic a, input int gap_tap, input int gap_len, output int lat);
    int n_eff;
    int k;
    int cnt;
    n_eff  = (n_req > MAX_TAPS) ? MAX_TAPS : n_req;
    start  = 1'b1;
    n_taps = NW'(n_req);
    bias   = b;
    sel    = s;
    af_en  = a;
    @(posedge clk); #1;
    k      = cyc;
    start  = 1'b0;
    n_taps = NW'($urandom);
    bias   = 16'($urandom);
    sel    = 2'($urandom);
    af_en  = 1'($urandom);
    for (int j = 0; j < n_eff; j++) begin
      cnt = 0;
      while (!in_ready && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (j == gap_tap) begin
        repeat (gap_len) begin
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      x_in     = xs[j];
      w_in     = ws[j];
      @(posedge clk); #1;
      in_valid = 1'b0;
      x_in     = 16'($urandom);
      w_in     = 16'($urandom);
    end
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    lat = out_valid ? (cyc - k) : -1;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 ext_reset_n = 1'b0;
    repeat (5) begin
      start     = 1'($urandom);
      n_taps    = NW'($urandom);
      bias      = 16'($urandom);
      sel       = 2'($urandom);
      af_en     = 1'($urandom);
      in_valid  = 1'($urandom);
      x_in      = 16'($urandom);
      w_in      = 16'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, sat, busy} !== 4'b0000)
        begin errors++; $display("FAIL reset_flags got %b want 0000", {in_ready, out_valid, sat, busy}); end
      checks++;
      if ({mac_out, z} !== 32'h0)
        begin errors++; $display("FAIL reset_data got mac=%h z=%h want 0", mac_out, z); end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ext_reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_two_taps(input string tag);
    int lat;
    xs[0] = 16'h0200; ws[0] = 16'h0200;
    xs[1] = 16'hFD80; ws[1] = 16'h0100;
    run_eval(2, 16'h0080, 2'b00, 1'b0, -1, 0, lat);
    checks++;
    if (lat !== 2 * TAP_LAT + 1) begin errors++; $display("FAIL %s_latency got %0d want %0d", tag, lat, 2 * TAP_LAT + 1); end
    checks++;
    if (rabs(sv(mac_out) - 224.0) > 8.0) begin errors++; $display("FAIL %s_mac got %h want 00e0 +-8", tag, mac_out); end
    checks++;
    if (rabs(sv(z) - 224.0) > 8.0) begin errors++; $display("FAIL %s_z got %h want 00e0 +-8", tag, z); end
    checks++;
    if (sat !== 1'b0) begin errors++; $display("FAIL %s_sat got %b want 0", tag, sat); end
    finish_out();
  endtask

  task automatic test_saturation();
    int lat;
    for (int j = 0; j < 8; j++) begin xs[j] = 16'h7C00; ws[j] = 16'h0600; end
    run_eval(8, 16'h0000, 2'b10, 1'b1, -1, 0, lat);
    checks++;
    if (lat !== 8 * TAP_LAT + 1) begin errors++; $display("FAIL sat_pos_latency got %0d want %0d", lat, 8 * TAP_LAT + 1); end
    checks++;
    if ({mac_out, z, sat} !== {16'h7FFF, 16'h0400, 1'b1})
      begin errors++; $display("FAIL sat_pos got mac=%h z=%h sat=%b want 7fff 0400 1", mac_out, z, sat); end
    finish_out();
    for (int j = 0; j < 8; j++) ws[j] = 16'hFA00;
    run_eval(8, 16'h0000, 2'b10, 1'b1, -1, 0, lat);
    checks++;
    if ({mac_out, z, sat} !== {16'h8000, 16'hFC00, 1'b1})
      begin errors++; $display("FAIL sat_neg got mac=%h z=%h sat=%b want 8000 fc00 1", mac_out, z, sat); end
    finish_out();
  endtask

  task automatic test_relu();
    int lat;
    xs[0] = 16'h0400; ws[0] = 16'hFE00;
    run_eval(1, 16'h0000, 2'b01, 1'b1, -1, 0, lat);
    checks++;
    if (lat !== TAP_LAT + 1) begin errors++; $display("FAIL relu_latency got %0d want %0d", lat, TAP_LAT + 1); end
    checks++;
    if (rabs(sv(mac_out) + 512.0) > 4.0) begin errors++; $display("FAIL relu_mac got %h want fe00 +-4", mac_out); end
    checks++;
    if (z !== 16'h0000) begin errors++; $display("FAIL relu_z got %h want 0000", z); end
    finish_out();
  endtask

  task automatic test_zero_sigmoid();
    int lat;
    run_eval(0, 16'h0000, 2'b11, 1'b1, -1, 0, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++;
    if ({mac_out, z, sat} !== {16'h0000, 16'h0200, 1'b0})
      begin errors++; $display("FAIL zero_sigmoid got mac=%h z=%h sat=%b want 0000 0200 0", mac_out, z, sat); end
    finish_out();
  endtask

  task automatic fill_random(input int n);
    int kx;
    for (int j = 0; j < n; j++) begin
      kx    = int'($urandom_range(0, 8)) - 4;
      xs[j] = 16'(kx * 512);
      ws[j] = 16'(int'($urandom_range(0, 4094)) - 2047);
    end
  endtask

  task automatic test_tap_clamp();
    int lat;
    real r;
    fill_random(9);
    run_eval(9, 16'h0100, 2'b11, 1'b1, -1, 0, lat);
    r = clamp_r(ref_sum(8, 16'h0100), -32768.0, 32767.0);
    checks++;
    if (lat !== 8 * TAP_LAT + 1) begin errors++; $display("FAIL clamp_latency got %0d want %0d", lat, 8 * TAP_LAT + 1); end
    checks++;
    if (rabs(sv(mac_out) - r) > 32.0) begin errors++; $display("FAIL clamp_mac got %h want %f +-32", mac_out, r); end
    checks++;
    if (rabs(sv(z) - act_r(r, 2'b11, 1'b1)) > 33.0)
      begin errors++; $display("FAIL clamp_z got %h want %f", z, act_r(r, 2'b11, 1'b1)); end
    finish_out();
  endtask

  task automatic test_backpressure();
    int lat;
    real r;
    fill_random(3);
    run_eval(3, 16'hFF00, 2'b00, 1'b1, 1, 3, lat);
    r = clamp_r(ref_sum(3, 16'hFF00), -32768.0, 32767.0);
    checks++;
    if (lat !== 3 * TAP_LAT + 1 + 3) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, 3 * TAP_LAT + 4); end
    checks++;
    if (rabs(sv(mac_out) - r) > 12.0) begin errors++; $display("FAIL bp_mac got %h want %f +-12", mac_out, r); end
    for (int c = 0; c < 5; c++) begin
      start  = 1'b1;
      n_taps = NW'(1);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, out_valid); end
      checks++;
      if (rabs(sv(mac_out) - r) > 12.0 || rabs(sv(z) - r) > 12.0)
        begin errors++; $display("FAIL bp_hold_data cycle %0d got mac=%h z=%h want %f +-12", c, mac_out, z, r); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", out_valid, busy); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    int n, bi, gtap, glen, lat, tol, elat;
    logic [15:0] b;
    logic [1:0] s;
    logic a;
    real r, m;
    for (int it = 0; it < 12; it++) begin
      n    = int'($urandom_range(0, 8));
      bi   = int'($urandom_range(0, 8192)) - 4096;
      b    = 16'(bi);
      s    = 2'($urandom);
      a    = 1'($urandom);
      gtap = (n > 0) ? int'($urandom_range(0, n - 1)) : -1;
      glen = int'($urandom_range(0, 2));
      fill_random(n);
      run_eval(n, b, s, a, gtap, glen, lat);
      elat = n * TAP_LAT + 1 + ((n > 0) ? glen : 0);
      tol  = 4 * n;
      r    = ref_sum(n, b);
      m    = clamp_r(r, -32768.0, 32767.0);
      checks++;
      if (lat !== elat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, elat); end
      checks++;
      if (rabs(sv(mac_out) - m) > real'(tol))
        begin errors++; $display("FAIL rand%0d_mac got %h want %f +-%0d", it, mac_out, m, tol); end
      checks++;
      if (rabs(sv(z) - act_r(m, s, a)) > real'(tol + 1))
        begin errors++; $display("FAIL rand%0d_z got %h want %f sel=%b af=%b", it, z, act_r(m, s, a), s, a); end
      if (r > 32768.0 + real'(tol) || r < -32769.0 - real'(tol)) begin
        checks++;
        if (sat !== 1'b1) begin errors++; $display("FAIL rand%0d_sat got %b want 1", it, sat); end
      end else if (r < 32766.0 - real'(tol) && r > -32767.0 + real'(tol)) begin
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL rand%0d_sat got %b want 0", it, sat); end
      end
      finish_out();
    end
  endtask

  task automatic test_reset_mid();
    xs[0] = 16'h0400; ws[0] = 16'h0600;
    start  = 1'b1;
    n_taps = NW'(2);
    bias   = 16'h0100;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    x_in     = xs[0];
    w_in     = ws[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 ext_reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, sat, busy} !== 4'b0000)
      begin errors++; $display("FAIL mid_reset_flags got %b want 0000", {in_ready, out_valid, sat, busy}); end
    checks++;
    if ({mac_out, z} !== 32'h0) begin errors++; $display("FAIL mid_reset_data got mac=%h z=%h want 0", mac_out, z); end
    @(posedge clk); #1;
    ext_reset_n = 1'b1;
    @(posedge clk); #1;
    test_two_taps("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_taps("two_taps");
    test_saturation();
    test_relu();
    test_zero_sigmoid();
    test_tap_clamp();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
